pipe_stall_ctrl: RTL

//   Central stall/flush scheduler for the 5-stage pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
//   - Sequences multi-cycle data-memory accesses and multi-cycle MUL/DIV operations.
//   - Resolves load-use hazards, taken branches and exceptions.
//   - Drives the stall and bubble (flush) inputs of every pipeline register from one place.

---
 rtl/pipe_stall_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for a 5-stage pipeline: sequences multi-cycle memory
// and MUL/DIV operations and resolves load-use, branch and exception hazards.
module pipe_stall_ctrl #(
    parameter int MEM_WAIT      = 2,
    parameter int MULDIV_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_load_use,
    input  logic       ex_muldiv_start,
    input  logic       ex_branch_taken,
    input  logic       mem_access,
    input  logic       exc_req,
    output logic [4:0] stall,
    output logic [3:0] flush,
    output logic       mem_ready,
    output logic       muldiv_busy,
    output logic       muldiv_done,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MEM    = 2'b01,
        ST_MULDIV = 2'b10
    } state_e;

    localparam bit MEM_MULTI = (MEM_WAIT > 0);
    localparam bit MD_MULTI  = (MULDIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = MEM_MULTI ? CNT_W'(MEM_WAIT - 1) : '0;
    localparam logic [CNT_W-1:0] MD_LOAD  = MD_MULTI ? CNT_W'(MULDIV_CYCLES - 2) : '0;

    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [3:0] FLUSH_MEM = 4'b1000;
    localparam logic [4:0] STALL_MD  = 5'b00111;
    localparam logic [3:0] FLUSH_MD  = 4'b0100;
    localparam logic [3:0] FLUSH_EXC = 4'b0111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // MUL/DIV countdown parked while a memory access pre-empts it
    logic [CNT_W-1:0] saved_cnt_q, saved_cnt_d;
    logic             resume_q, resume_d;

    logic [4:0] stall_c;
    logic [3:0] flush_c;
    logic       mem_ready_c;
    logic       busy_c;
    logic       done_c;
    logic       ex_eval;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        saved_cnt_d = saved_cnt_q;
        resume_d    = resume_q;
        stall_c     = '0;
        flush_c     = '0;
        mem_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        ex_eval     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    flush_c = FLUSH_EXC;
                    cnt_d   = '0;
                end else if (mem_access && MEM_MULTI) begin
                    stall_c = STALL_MEM;
                    flush_c = FLUSH_MEM;
                    cnt_d   = MEM_LOAD;
                    state_d = ST_MEM;
                end else begin
                    mem_ready_c = mem_access;
                    ex_eval     = 1'b1;
                end
            end

            ST_MEM: begin
                if (exc_req) begin
                    flush_c  = FLUSH_EXC;
                    cnt_d    = '0;
                    resume_d = 1'b0;
                    state_d  = ST_RUN;
                end else if (cnt_q != '0) begin
                    stall_c = STALL_MEM;
                    flush_c = FLUSH_MEM;
                    busy_c  = resume_q;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    mem_ready_c = 1'b1;
                    state_d     = ST_RUN;
                    if (resume_q) begin
                        // EX still holds the suspended MUL/DIV: keep it held
                        stall_c  = STALL_MD;
                        flush_c  = FLUSH_MD;
                        busy_c   = 1'b1;
                        cnt_d    = saved_cnt_q;
                        resume_d = 1'b0;
                        state_d  = ST_MULDIV;
                    end else begin
                        ex_eval = 1'b1;
                    end
                end
            end

            ST_MULDIV: begin
                if (exc_req) begin
                    flush_c = FLUSH_EXC;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (mem_access && MEM_MULTI) begin
                    // Memory pre-empts: hold EX_MEM instead of bubbling it, freeze the count
                    stall_c     = STALL_MEM;
                    flush_c     = FLUSH_MEM;
                    busy_c      = 1'b1;
                    saved_cnt_d = cnt_q;
                    resume_d    = 1'b1;
                    cnt_d       = MEM_LOAD;
                    state_d     = ST_MEM;
                end else begin
                    mem_ready_c = mem_access;
                    busy_c      = 1'b1;
                    if (cnt_q != '0) begin
                        stall_c = STALL_MD;
                        flush_c = FLUSH_MD;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        done_c  = 1'b1;
                        state_d = ST_RUN;
                        ex_eval = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = ST_RUN;
                cnt_d    = '0;
                resume_d = 1'b0;
            end
        endcase

        // EX/ID requests, evaluated only when those stages are free to advance
        if (ex_eval) begin
            if (ex_muldiv_start) begin
                if (MD_MULTI) begin
                    stall_c = stall_c | STALL_MD;
                    flush_c = flush_c | FLUSH_MD;
                    busy_c  = 1'b1;
                    cnt_d   = MD_LOAD;
                    state_d = ST_MULDIV;
                end else begin
                    done_c = 1'b1;
                end
            end else begin
                if (ex_branch_taken) begin
                    flush_c[0] = 1'b1;
                end
                if (id_load_use) begin
                    flush_c[1] = 1'b1;
                    if (!ex_branch_taken) begin
                        stall_c = stall_c | 5'b00011;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            saved_cnt_q <= '0;
            resume_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            saved_cnt_q <= saved_cnt_d;
            resume_q    <= resume_d;
        end
    end

    // Flush wins over stall on the same register; everything is forced low in reset
    always_comb begin
        stall       = '0;
        flush       = '0;
        mem_ready   = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_done = 1'b0;
        ctrl_state  = 2'b00;
        if (rst) begin
            stall       = {stall_c[4:1] & ~flush_c, stall_c[0]};
            flush       = flush_c;
            mem_ready   = mem_ready_c;
            muldiv_busy = busy_c;
            muldiv_done = done_c;
            ctrl_state  = state_q;
        end
    end

endmodule
